// File: rtl/fp16_pkg.sv
// Shared half-precision FP definitions: flag bit positions, CSR address map,
// rounding modes and the CSR bus handshake states.
package fp16_pkg;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef enum logic [1:0] {
        CSR_FFLAGS  = 2'd0,
        CSR_FRM     = 2'd1,
        CSR_FCSR    = 2'd2,
        CSR_TRAP_EN = 2'd3
    } csr_addr_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4,
        RM_DYN = 3'd7
    } rm_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    // Encodings 5 and 6 are reserved rounding modes.
    function automatic logic rm_legal(input logic [2:0] v);
        return !((v == 3'd5) || (v == 3'd6));
    endfunction

endpackage

// File: rtl/fp_flag_csr.sv
// FP exception-flag / rounding-mode CSR for the FP16 FMA unit.
// Optional trap support is compiled in with FP_FLAG_TRAP_EN.
module fp_flag_csr
    import fp16_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       res_valid,
    input  logic       flag_nv,
    input  logic       flag_of,
    input  logic       flag_uf,
    input  logic       flag_nx,
    input  logic       csr_req,
    input  logic       csr_we,
    input  logic [1:0] csr_addr,
    input  logic [7:0] csr_wdata,
    output logic       csr_ack,
    output logic [7:0] csr_rdata,
    output logic       csr_err,
    output logic [2:0] frm,
    output logic       fp_trap
);

    // Bus handshake: a request is accepted only in IDLE; the following cycle
    // (RESP) presents ack with rdata/err, then the bus returns to IDLE.
    bus_state_e r_state;
    bus_state_e w_state_nxt;
    logic       w_accept;

    logic       r_stage_v;
    logic [4:0] r_stage_f;
    logic [4:0] r_fflags;
    logic [2:0] r_frm;
    logic [7:0] r_rdata;
    logic       r_err;

    logic       w_wr_fflags;
    logic       w_frm_target;
    logic [2:0] w_frm_wval;
    logic       w_frm_bad;
    logic [4:0] w_stage_or;
    logic [4:0] w_fflags_nxt;
    logic [7:0] w_rdata;
    logic [3:0] w_trap_en;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            BUS_IDLE: begin
                if (csr_req) begin
                    w_state_nxt = BUS_RESP;
                    w_accept    = 1'b1;
                end
            end
            BUS_RESP: w_state_nxt = BUS_IDLE;
            default:  w_state_nxt = BUS_IDLE;
        endcase
    end

    assign w_wr_fflags  = w_accept && csr_we &&
                          ((csr_addr == CSR_FFLAGS) || (csr_addr == CSR_FCSR));
    assign w_frm_target = w_accept && csr_we &&
                          ((csr_addr == CSR_FRM) || (csr_addr == CSR_FCSR));
    assign w_frm_wval   = (csr_addr == CSR_FCSR) ? csr_wdata[7:5] : csr_wdata[2:0];
    assign w_frm_bad    = w_frm_target && !rm_legal(w_frm_wval);

    assign w_stage_or   = r_stage_v ? r_stage_f : 5'b0;
    assign w_fflags_nxt = (w_wr_fflags ? csr_wdata[4:0] : r_fflags) | w_stage_or;

    always_comb begin
        w_rdata = 8'h00;
        case (csr_addr)
            CSR_FFLAGS:  w_rdata = {3'b000, r_fflags};
            CSR_FRM:     w_rdata = {5'b00000, r_frm};
            CSR_FCSR:    w_rdata = {r_frm, r_fflags};
            CSR_TRAP_EN: w_rdata = {4'b0000, w_trap_en};
            default:     w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= BUS_IDLE;
            r_stage_v <= 1'b0;
            r_stage_f <= 5'b0;
            r_fflags  <= 5'b0;
            r_frm     <= RM_RNE;
            r_rdata   <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_stage_v <= res_valid;
            if (res_valid) begin
                r_stage_f <= {flag_nv, 1'b0, flag_of, flag_uf, flag_nx};
            end
            r_fflags  <= w_fflags_nxt;
            if (w_frm_target && !w_frm_bad) begin
                r_frm <= w_frm_wval;
            end
            // rdata/err hold the pre-update snapshot only for the RESP cycle.
            r_rdata   <= w_accept ? w_rdata : 8'h00;
            r_err     <= w_frm_bad;
        end
    end

`ifdef FP_FLAG_TRAP_EN
    logic [3:0] r_trap_en;
    logic       r_trap;
    logic [4:0] w_en_mask;
    logic       w_trap_hit;

    // Only bits newly set by the flag stage raise a trap; software writes never do.
    assign w_en_mask  = {r_trap_en[3], 1'b0, r_trap_en[2:0]};
    assign w_trap_hit = |(w_stage_or & ~r_fflags & w_en_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trap_en <= 4'b0;
            r_trap    <= 1'b0;
        end else begin
            if (w_accept && csr_we && (csr_addr == CSR_TRAP_EN)) begin
                r_trap_en <= csr_wdata[3:0];
            end
            r_trap <= w_trap_hit;
        end
    end

    assign w_trap_en = r_trap_en;
    assign fp_trap   = r_trap;
`else
    assign w_trap_en = 4'b0;
    assign fp_trap   = 1'b0;
`endif

    assign csr_ack   = (r_state == BUS_RESP);
    assign csr_rdata = r_rdata;
    assign csr_err   = r_err;
    assign frm       = r_frm;

endmodule

// File: tb/tb_fp_flag_csr.sv
// Scoreboard bench for fp_flag_csr: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the flag/CSR rules.
module tb_fp_flag_csr;

    logic       clk = 1'b0;
    logic       reset;
    logic       res_valid;
    logic       flag_nv, flag_of, flag_uf, flag_nx;
    logic       csr_req, csr_we;
    logic [1:0] csr_addr;
    logic [7:0] csr_wdata;
    logic       csr_ack;
    logic [7:0] csr_rdata;
    logic       csr_err;
    logic [2:0] frm;
    logic       fp_trap;

    always #5 clk = ~clk;

    fp_flag_csr dut (
        .clk       (clk),
        .reset     (reset),
        .res_valid (res_valid),
        .flag_nv   (flag_nv),
        .flag_of   (flag_of),
        .flag_uf   (flag_uf),
        .flag_nx   (flag_nx),
        .csr_req   (csr_req),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_ack   (csr_ack),
        .csr_rdata (csr_rdata),
        .csr_err   (csr_err),
        .frm       (frm),
        .fp_trap   (fp_trap)
    );

`ifdef FP_FLAG_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard: {err, rdata} expected on the ack that is due in cycle due_q.
    logic [8:0] exp_q[$];
    int         due_q[$];

    // Architectural model state.
    logic [4:0] m_fflags;
    logic [2:0] m_frm;
    logic [3:0] m_trap_en;
    logic [4:0] m_pending;   // flags of a result strobed last cycle, not yet sticky
    logic       m_busy;      // a response is being returned this cycle
    logic       exp_trap;
    logic [8:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {3'b000, m_fflags};
            2'd1:    return {5'b00000, m_frm};
            2'd2:    return {m_frm, m_fflags};
            default: return TRAP_ON ? {4'b0000, m_trap_en} : 8'h00;
        endcase
    endfunction

    function automatic logic rm_reserved(input logic [2:0] v);
        return (v == 3'd5) || (v == 3'd6);
    endfunction

    // Monitor: compares every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            check("ack", 32'(csr_ack), 32'd1);
            mon_e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("rdata", 32'(csr_rdata), 32'(mon_e[7:0]));
            check("err", 32'(csr_err), 32'(mon_e[8]));
        end else begin
            check("idle_ack", 32'(csr_ack), 32'd0);
            check("idle_rdata", 32'(csr_rdata), 32'd0);
            check("idle_err", 32'(csr_err), 32'd0);
        end
        check("fp_trap", 32'(fp_trap), 32'(exp_trap));
        check("frm", 32'(frm), 32'(m_frm));
    end

    task automatic model_clear();
        exp_q.delete();
        due_q.delete();
        m_fflags  = '0;
        m_frm     = '0;
        m_trap_en = '0;
        m_pending = '0;
        m_busy    = 1'b0;
        exp_trap  = 1'b0;
    endtask

    // fl = {nv, of, uf, nx}
    task automatic step(input logic rv, input logic [3:0] fl, input logic rq,
                        input logic we, input logic [1:0] a, input logic [7:0] wd);
        logic       acc;
        logic [2:0] rmv;
        logic [4:0] base;
        logic [4:0] en_mask;
        @(negedge clk);
        res_valid = rv;
        {flag_nv, flag_of, flag_uf, flag_nx} = fl;
        csr_req   = rq;
        csr_we    = we;
        csr_addr  = a;
        csr_wdata = wd;
        @(posedge clk);
        cyc++;
        acc = rq && !m_busy;
        rmv = (a == 2'd2) ? wd[7:5] : wd[2:0];
        if (acc) begin
            exp_q.push_back({we && (a == 2'd1 || a == 2'd2) && rm_reserved(rmv), model_read(a)});
            due_q.push_back(cyc);
        end
        base     = (acc && we && (a == 2'd0 || a == 2'd2)) ? wd[4:0] : m_fflags;
        en_mask  = {m_trap_en[3], 1'b0, m_trap_en[2:0]};
        exp_trap = TRAP_ON && ((m_pending & ~m_fflags & en_mask) != 5'b0);
        m_fflags = base | m_pending;
        if (acc && we && (a == 2'd1 || a == 2'd2) && !rm_reserved(rmv)) m_frm = rmv;
        if (TRAP_ON && acc && we && a == 2'd3) m_trap_en = wd[3:0];
        m_pending = rv ? {fl[3], 1'b0, fl[2:0]} : 5'b0;
        m_busy    = acc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, 4'b0, 1'b1, 1'b0, a, 8'h00);
        idle(1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        step(1'b0, 4'b0, 1'b1, 1'b1, a, d);
        idle(1);
    endtask

    task automatic apply_reset(input logic rv_during);
        reset     = 1'b1;
        res_valid = rv_during;
        flag_nv   = rv_during;
        flag_nx   = rv_during;
        csr_req   = 1'b0;
        model_clear();
        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        res_valid = 1'b0;
        flag_nv   = 1'b0;
        flag_nx   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        res_valid = 0; flag_nv = 0; flag_of = 0; flag_uf = 0; flag_nx = 0;
        csr_req = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
        model_clear();
        apply_reset(1'b0);
        for (int a = 0; a < 4; a++) rd(2'(a));

        // nv+nx strobed, read two cycles later.
        step(1'b1, 4'b1001, 1'b0, 1'b0, 2'd0, 8'h00);
        idle(1);
        rd(2'd0);

        // Stickiness: of, then a clean result; only a write clears.
        wr(2'd0, 8'h00);
        step(1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
        idle(2);
        rd(2'd0);
        wr(2'd0, 8'h00);
        idle(1);
        rd(2'd0);

        // Write coincident with a staged uf.
        step(1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h00);
        idle(1);
        rd(2'd0);

        // Reserved rounding mode via fcsr, then a legal one via frm.
        wr(2'd2, 8'hBF);
        rd(2'd2);
        wr(2'd1, 8'h03);
        rd(2'd1);

        // Back-to-back request during RESP is ignored.
        step(1'b0, 4'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        step(1'b0, 4'b0, 1'b1, 1'b1, 2'd0, 8'hFF);
        idle(1);
        rd(2'd0);

        for (int v = 0; v < 8; v++) begin
            wr(2'd1, 8'(v));
            rd(2'd1);
        end

        // Trap enable on NV: first nv traps, second (already sticky) does not.
        wr(2'd3, 8'h08);
        rd(2'd3);
        wr(2'd0, 8'h00);
        idle(2);
        step(1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 8'h00);
        idle(3);
        step(1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 8'h00);
        idle(3);

        // Reset in the middle of a response, with a strobe during reset.
        step(1'b0, 4'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        #2;
        apply_reset(1'b1);
        idle(2);
        for (int a = 0; a < 4; a++) rd(2'(a));

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
        end
        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_flag_csr.md
FP_FLAG_CSR -- requirements
Module: fp_flag_csr

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: res_valid  in  1  FMA result strobe; flags below sampled only when high.
REQ-004 SHALL have ports: flag_nv, flag_of, flag_uf, flag_nx  in  1 each  exception flags of the strobed result.
REQ-005 SHALL have ports: csr_req  in  1; csr_we  in  1; csr_addr  in  2; csr_wdata  in  8  software access request.
REQ-006 SHALL have ports: csr_ack  out  1; csr_rdata  out  8; csr_err  out  1  access response.
REQ-007 SHALL have ports: frm  out  3  rounding mode driven to the FMA datapath.
REQ-008 SHALL have ports: fp_trap  out  1  trap pulse (see Configuration).

Function
REQ-009 SHALL hold fflags[4:0] = {NV,DZ,OF,UF,NX}; DZ always 0 (half-precision FMA never divides).
REQ-010 SHALL register flags in one capture stage: at edge with res_valid=1, stage_v<=1, stage_f<={nv,0,of,uf,nx}; else stage_v<=0.
REQ-011 SHALL update sticky state each edge: fflags <= (fflags_wr ? wdata[4:0] : fflags) | (stage_v ? stage_f : 0); flags visible to a read 2 cycles after res_valid.
REQ-012 SHALL never clear a fflags bit except by software write or reset.
REQ-013 SHALL map addresses: 0 fflags (rdata={3'b0,fflags}); 1 frm (rdata={5'b0,frm}); 2 fcsr (rdata={frm,fflags}); 3 trap-enable (rdata={4'b0,trap_en}).
REQ-014 SHALL implement bus FSM IDLE/RESP: IDLE & csr_req -> RESP, latching addr/we/wdata and read data; RESP -> IDLE unconditionally; csr_req ignored while in RESP.
REQ-015 SHALL assert csr_ack for exactly the RESP cycle; csr_rdata and csr_err valid only then, 0 otherwise.
REQ-016 SHALL return read data sampled at the request-accept edge (pre-update value).
REQ-017 SHALL commit writes at the request-accept edge; simultaneous stage flags OR onto written fflags per REQ-011.
REQ-018 SHALL reject frm writes of 5 or 6 (via addr 1 or 2): frm unchanged, csr_err=1; fflags part of an addr-2 write still commits.
REQ-019 SHALL accept frm values 0-4 and 7 unchanged.

Reset
REQ-020 SHALL on reset clear fflags, frm (0=RNE), trap_en, stage_v, stage_f; FSM to IDLE; csr_ack, csr_rdata, csr_err, fp_trap all 0.
REQ-021 SHALL abort an in-flight RESP on reset; no ack is issued for it after release.
REQ-022 SHALL discard a res_valid coincident with reset assertion.

Configuration
REQ-023 SHALL compile trap support only when FP_FLAG_TRAP_EN is defined.
REQ-024 With FP_FLAG_TRAP_EN: trap_en[3:0] enables {NV,OF,UF,NX}; fp_trap pulses 1 cycle, the cycle after any enabled bit transitions 0->1 in fflags by stage update (not by software write).
REQ-025 Without FP_FLAG_TRAP_EN: fp_trap tied 0; addr 3 reads 0, writes ignored, csr_err=0.

Structure
REQ-026 SHALL place in shared package fp16_pkg: flag-bit index constants, CSR address enum, rounding-mode enum (RNE=0,RTZ=1,RDN=2,RUP=3,RMM=4,DYN=7).
REQ-027 SHALL be one module; no sub-module.

Verification
REQ-028 Reset: pulse reset mid-RESP -> ack never seen, all reads 0.
REQ-029 res_valid with nv=1,nx=1 at cycle 0; read addr 0 at cycle 2 -> rdata=8'h11, ack 1 cycle.
REQ-030 Sticky: flags of=1 then later all 0 -> fflags stays 8'h04 until write addr0 wdata=0 -> reads 0.
REQ-031 Write addr 0 wdata=0 coincident with stage uf=1 -> fflags=8'h02.
REQ-032 Write addr 2 wdata=8'hBF -> frm stays 0, fflags=1F&~DZ... stored 5'h1F, csr_err=1; write addr 1 wdata=3 -> frm=3, err=0.
REQ-033 FP_FLAG_TRAP_EN: trap_en=4'b1000, nv raised -> single fp_trap pulse; second nv -> no pulse.
